// File: rtl/perf_counter_bank.sv
// ============================================================================
// perf_counter_bank
// ----------------------------------------------------------------------------
// Parametrised performance-counter bank. Each of NUM_CH channels counts its
// event strobe while counting is enabled and not frozen. Counters either wrap
// or saturate (SAT). A sticky per-channel flag records overflow/saturation.
// A shadow bank captures all live counters on 'snap'. When 'snap' and
// 'sw_clear' are asserted together, the bank is read and cleared atomically.
// There is one registered read port with 1-cycle latency.
//
// Optional feature macro: PERF_THRESH_EN
//   When defined, adds a 'thresh' input and an 'irq' output. irq is sticky.
//   It is set when any channel increments to a value equal to 'thresh'.
//   sw_clear or reset clears it.
//
// Ports
//   clk       in  1       system clock, rising edge
//   clr       in  1       asynchronous active-low reset
//   ev        in  NUM_CH  per-channel event strobes
//   cnt_en    in  1       global count enable
//   freeze    in  1       hold all counters (overrides cnt_en)
//   sw_clear  in  1       synchronous clear of live counters, ovf (and irq)
//   snap      in  1       copy live counters into the shadow bank
//   rd_src    in  1       0 = live bank, 1 = shadow bank
//   rd_sel    in  SEL_W   channel to read (>= NUM_CH reads 0)
//   rd_data   out CNT_W   registered read data
//   ovf       out NUM_CH  sticky overflow/saturation flags
//   snap_vld  out 1       shadow bank holds a snapshot since reset
//   thresh    in  CNT_W   (PERF_THRESH_EN) interrupt threshold
//   irq       out 1       (PERF_THRESH_EN) sticky threshold interrupt
// ============================================================================
module perf_counter_bank #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int SAT    = 0,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [NUM_CH-1:0] ev,
    input  logic              cnt_en,
    input  logic              freeze,
    input  logic              sw_clear,
    input  logic              snap,
    input  logic              rd_src,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] ovf,
    output logic              snap_vld
`ifdef PERF_THRESH_EN
    ,
    input  logic [CNT_W-1:0]  thresh,
    output logic              irq
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NUM_CH-1:0][CNT_W-1:0] live_r;
    logic [NUM_CH-1:0][CNT_W-1:0] shadow_r;
    logic [NUM_CH-1:0][CNT_W-1:0] live_nxt_s;
    logic [NUM_CH-1:0]            ovf_nxt_s;
    logic [NUM_CH-1:0]            inc_s;
    logic                         gate_s;
    logic [CNT_W-1:0]             rd_mux_s;
`ifdef PERF_THRESH_EN
    logic [NUM_CH-1:0]            hit_s;
`endif

    // Per-channel increment qualifiers; sw_clear suppresses counting in its cycle.
    always_comb begin
        gate_s = cnt_en & ~freeze & ~sw_clear;
        inc_s  = ev & {NUM_CH{gate_s}};
    end

    // Next-state of every live counter and its sticky overflow flag.
    always_comb begin
        live_nxt_s = live_r;
        ovf_nxt_s  = ovf;
`ifdef PERF_THRESH_EN
        hit_s      = {NUM_CH{1'b0}};
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (sw_clear) begin
                live_nxt_s[i] = CNT_ZERO;
                ovf_nxt_s[i]  = 1'b0;
            end else if (inc_s[i]) begin
                if (live_r[i] == CNT_MAX) begin
                    // Wrap-to-0 or hold at max; neither counts as a threshold hit.
                    ovf_nxt_s[i]  = 1'b1;
                    live_nxt_s[i] = (SAT != 0) ? CNT_MAX : CNT_ZERO;
                end else begin
                    live_nxt_s[i] = live_r[i] + CNT_ONE;
`ifdef PERF_THRESH_EN
                    hit_s[i]      = ((live_r[i] + CNT_ONE) == thresh);
`endif
                end
            end else begin
                live_nxt_s[i] = live_r[i];
                ovf_nxt_s[i]  = ovf[i];
            end
        end
    end

    // Read mux: OR of one-hot channel matches, so an unmatched select yields 0.
    always_comb begin
        rd_mux_s = CNT_ZERO;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_mux_s = rd_mux_s |
                       ((rd_sel == SEL_W'(i)) ? (rd_src ? shadow_r[i] : live_r[i]) : CNT_ZERO);
        end
    end

    // Live counters and sticky overflow flags.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            live_r <= '0;
            ovf    <= {NUM_CH{1'b0}};
        end else begin
            live_r <= live_nxt_s;
            ovf    <= ovf_nxt_s;
        end
    end

    // Shadow bank captures the pre-edge live values; this makes snap+sw_clear atomic.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            shadow_r <= '0;
            snap_vld <= 1'b0;
        end else if (snap) begin
            shadow_r <= live_r;
            snap_vld <= 1'b1;
        end else begin
            shadow_r <= shadow_r;
            snap_vld <= snap_vld;
        end
    end

    // Registered read port; a live read returns the value before this edge's increment.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rd_data <= CNT_ZERO;
        end else begin
            rd_data <= rd_mux_s;
        end
    end

`ifdef PERF_THRESH_EN
    // Sticky threshold interrupt.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            irq <= 1'b0;
        end else if (sw_clear) begin
            irq <= 1'b0;
        end else if (|hit_s) begin
            irq <= 1'b1;
        end else begin
            irq <= irq;
        end
    end
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// ============================================================================
// tb_perf_counter_bank
// Directed bench for three instances that share stimulus:
//   dut_a : NUM_CH=4, CNT_W=32, SAT=0
//   dut_w : NUM_CH=4, CNT_W=8,  SAT=0 (wrap)
//   dut_s : NUM_CH=4, CNT_W=8,  SAT=1 (saturate)
// Inputs change 1 time unit after the rising edge. Outputs are sampled there.
// ============================================================================
module tb_perf_counter_bank;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  ev = 4'b0000;
    logic        cnt_en = 1'b0;
    logic        freeze = 1'b0;
    logic        sw_clear = 1'b0;
    logic        snap = 1'b0;
    logic        rd_src = 1'b0;
    logic [3:0]  rd_sel = 4'd0;

    logic [31:0] rd_data_a;
    logic [7:0]  rd_data_w;
    logic [7:0]  rd_data_s;
    logic [3:0]  ovf_a, ovf_w, ovf_s;
    logic        snap_vld_a, snap_vld_w, snap_vld_s;
`ifdef PERF_THRESH_EN
    logic [31:0] thresh_a = 32'd3;
    logic [7:0]  thresh_8 = 8'd3;
    logic        irq_a, irq_w, irq_s;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_CH(4), .CNT_W(32), .SAT(0), .SEL_W(4)) dut_a (
        .clk(clk), .clr(clr), .ev(ev), .cnt_en(cnt_en), .freeze(freeze),
        .sw_clear(sw_clear), .snap(snap), .rd_src(rd_src), .rd_sel(rd_sel),
        .rd_data(rd_data_a), .ovf(ovf_a), .snap_vld(snap_vld_a)
`ifdef PERF_THRESH_EN
        , .thresh(thresh_a), .irq(irq_a)
`endif
    );

    perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .SAT(0), .SEL_W(4)) dut_w (
        .clk(clk), .clr(clr), .ev(ev), .cnt_en(cnt_en), .freeze(freeze),
        .sw_clear(sw_clear), .snap(snap), .rd_src(rd_src), .rd_sel(rd_sel),
        .rd_data(rd_data_w), .ovf(ovf_w), .snap_vld(snap_vld_w)
`ifdef PERF_THRESH_EN
        , .thresh(thresh_8), .irq(irq_w)
`endif
    );

    perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .SAT(1), .SEL_W(4)) dut_s (
        .clk(clk), .clr(clr), .ev(ev), .cnt_en(cnt_en), .freeze(freeze),
        .sw_clear(sw_clear), .snap(snap), .rd_src(rd_src), .rd_sel(rd_sel),
        .rd_data(rd_data_s), .ovf(ovf_s), .snap_vld(snap_vld_s)
`ifdef PERF_THRESH_EN
        , .thresh(thresh_8), .irq(irq_s)
`endif
    );

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        #2;
        check("reset_rd_data", 64'(rd_data_a), 64'd0);
        check("reset_ovf",     64'(ovf_a),     64'd0);
        check("reset_snapvld", 64'(snap_vld_a), 64'd0);
        tick();
        tick();
        clr = 1'b1;

        // ---------------- ch0 counts 10 events ----------------
        ev = 4'b0001; cnt_en = 1'b1; rd_sel = 4'd0; rd_src = 1'b0;
        repeat (10) tick();
        check("cnt10_preinc_rd", 64'(rd_data_a), 64'd9);
        ev = 4'b0000;
        tick();
        check("cnt10_rd_a", 64'(rd_data_a), 64'd10);
        check("cnt10_rd_s", 64'(rd_data_s), 64'd10);
`ifdef PERF_THRESH_EN
        check("irq_from_ch0", 64'(irq_a), 64'd1);
`endif

        // ---------------- cnt_en=0 / freeze=1 hold ----------------
        ev = 4'b1111; cnt_en = 1'b0;
        repeat (5) tick();
        check("hold_cnt_en0", 64'(rd_data_a), 64'd10);
        cnt_en = 1'b1; freeze = 1'b1;
        repeat (5) tick();
        check("hold_freeze", 64'(rd_data_a), 64'd10);
        rd_sel = 4'd5;
        tick();
        check("rd_sel_oob", 64'(rd_data_a), 64'd0);
        check("hold_ovf", 64'(ovf_a), 64'd0);
        freeze = 1'b0; ev = 4'b0000;

        // ---------------- ch1 to 255, then overflow ----------------
        ev = 4'b0010; rd_sel = 4'd1;
        repeat (255) tick();
        ev = 4'b0000;
        tick();
        check("pre_ovf_rd_w", 64'(rd_data_w), 64'd255);
        check("pre_ovf_ovf_w", 64'(ovf_w), 64'd0);
        ev = 4'b0010;
        tick();
        ev = 4'b0000;
        check("wrap_ovf_w", 64'(ovf_w), 64'b0010);
        check("sat_ovf_s",  64'(ovf_s), 64'b0010);
        check("no_ovf_a",   64'(ovf_a), 64'd0);
        tick();
        check("wrap_rd_w", 64'(rd_data_w), 64'd0);
        check("sat_rd_s",  64'(rd_data_s), 64'd255);
        check("wide_rd_a", 64'(rd_data_a), 64'd256);
        ev = 4'b0010;
        repeat (3) tick();
        ev = 4'b0000;
        tick();
        check("sat_hold_s",  64'(rd_data_s), 64'd255);
        check("wrap_cont_w", 64'(rd_data_w), 64'd3);
        check("wide_cont_a", 64'(rd_data_a), 64'd259);
        check("ovf_sticky_w", 64'(ovf_w), 64'b0010);

        // ---------------- ch2=7, snap + sw_clear ----------------
        ev = 4'b0100;
        repeat (7) tick();
        ev = 4'b0100; snap = 1'b1; sw_clear = 1'b1;
        tick();
        ev = 4'b0000; snap = 1'b0; sw_clear = 1'b0;
        check("snapclr_vld_a", 64'(snap_vld_a), 64'd1);
        check("snapclr_vld_w", 64'(snap_vld_w), 64'd1);
        check("snapclr_vld_s", 64'(snap_vld_s), 64'd1);
        check("snapclr_ovf_w", 64'(ovf_w), 64'd0);
        check("snapclr_ovf_s", 64'(ovf_s), 64'd0);
`ifdef PERF_THRESH_EN
        check("snapclr_irq_a", 64'(irq_a), 64'd0);
`endif
        rd_src = 1'b1; rd_sel = 4'd2;
        tick();
        check("shadow2_a", 64'(rd_data_a), 64'd7);
        rd_sel = 4'd1;
        tick();
        check("shadow1_a", 64'(rd_data_a), 64'd259);
        check("shadow1_s", 64'(rd_data_s), 64'd255);
        rd_src = 1'b0; rd_sel = 4'd2;
        tick();
        check("live2_cleared", 64'(rd_data_a), 64'd0);

        // snap alone captures the pre-increment value
        ev = 4'b0100; snap = 1'b1;
        tick();
        ev = 4'b0000; snap = 1'b0; rd_src = 1'b1;
        tick();
        check("snap_preinc_shadow", 64'(rd_data_a), 64'd0);
        rd_src = 1'b0;
        tick();
        check("snap_preinc_live", 64'(rd_data_a), 64'd1);

        // ---------------- threshold: ch0 pulses 3x ----------------
        ev = 4'b0001;
        tick();
        ev = 4'b0000;
        tick();
        ev = 4'b0001;
        tick();
        ev = 4'b0000;
`ifdef PERF_THRESH_EN
        check("irq_after_2", 64'(irq_a), 64'd0);
`endif
        tick();
        ev = 4'b0001;
        tick();
        ev = 4'b0000;
`ifdef PERF_THRESH_EN
        check("irq_after_3_a", 64'(irq_a), 64'd1);
        check("irq_after_3_w", 64'(irq_w), 64'd1);
`endif
        rd_sel = 4'd0;
        tick();
        check("ch0_three", 64'(rd_data_a), 64'd3);
        sw_clear = 1'b1;
        tick();
        sw_clear = 1'b0;
`ifdef PERF_THRESH_EN
        check("irq_cleared", 64'(irq_a), 64'd0);
`endif

        // ---------------- reset mid-count ----------------
        ev = 4'b1111; snap = 1'b1;
        tick();
        snap = 1'b0;
        repeat (2) tick();
        check("midcnt_rd", 64'(rd_data_a), 64'd2);
        check("midcnt_vld", 64'(snap_vld_a), 64'd1);
        #2;
        clr = 1'b0;
        #1;
        check("async_rd", 64'(rd_data_a), 64'd0);
        check("async_vld", 64'(snap_vld_a), 64'd0);
        check("async_ovf_w", 64'(ovf_w), 64'd0);
        ev = 4'b0000;
        tick();
        clr = 1'b1;
        tick();
        check("post_rst_live", 64'(rd_data_a), 64'd0);
        rd_src = 1'b1;
        tick();
        check("post_rst_shadow", 64'(rd_data_a), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
